// File: rtl/dm_pkg.sv
// Shared definitions for the data memory LSU: funct3 field encodings, FSM states
// and small address/size helpers used by the top and the lane aligner.
package dm_pkg;

  localparam int DM_XLEN       = 64;
  localparam int DM_WORD_BYTES = DM_XLEN / 8;

  // funct3[1:0] access size, funct3[2] selects zero-extension on loads
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  localparam int         F3_UNSIGNED_BIT = 2;
  localparam logic [2:0] F3_ILLEGAL_LOAD = 3'b111;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

  function automatic logic misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
    logic [2:0] mask;
    mask = 3'((4'd1 << size) - 4'd1);
    return |(addr_lo & mask);
  endfunction

endpackage

// File: rtl/data_memory_lsu_if.sv
// Request/response bus between the execute stage (master) and the data memory LSU (slave).
interface data_memory_lsu_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_fault;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );

endinterface

// File: rtl/dm_lane_align.sv
// Byte-lane steering: store byte-enables and data placement, plus load byte
// selection with sign/zero extension to a full 64-bit result.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [2:0]         funct3,
  input  logic [2:0]         lane,
  input  logic [DM_XLEN-1:0] st_data,
  input  logic [DM_XLEN-1:0] rd_word,
  output logic [7:0]         st_be,
  output logic [DM_XLEN-1:0] st_word,
  output logic [DM_XLEN-1:0] ld_data
);

  logic [7:0]         be_base;
  logic [DM_XLEN-1:0] shifted;
  logic               is_unsigned;

  always_comb begin
    // NOTE: every output gets a default before the case so no latch can be inferred.
    be_base     = 8'((9'd1 << size_bytes(funct3)) - 9'd1);
    st_be       = be_base << lane;
    st_word     = st_data << {lane, 3'b000};
    shifted     = rd_word >> {lane, 3'b000};
    is_unsigned = funct3[F3_UNSIGNED_BIT];
    ld_data     = shifted;

    case (funct3[1:0])
      SZ_B: ld_data = {{56{~is_unsigned & shifted[7]}},  shifted[7:0]};
      SZ_H: ld_data = {{48{~is_unsigned & shifted[15]}}, shifted[15:0]};
      SZ_W: ld_data = {{32{~is_unsigned & shifted[31]}}, shifted[31:0]};
      SZ_D: ld_data = shifted;
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/data_memory_lsu.sv
// Data memory with RISC-V load/store semantics: zeroing sweep after reset, then one
// fully pipelined request per cycle with a registered response and fault reporting.
module data_memory_lsu
  import dm_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 64
) (
  input logic              clk,
  input logic              rstn,
  data_memory_lsu_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  state_e          state;
  state_e          state_nxt;
  logic [AW-1:0]   init_ptr;
  logic            init_we;

  logic [XLEN-1:0] mem [0:DEPTH-1];

  logic            accept;
  logic [AW-1:0]   word_idx;
  logic [2:0]      lane;
  logic            fault_mis;
  logic            fault_range;
  logic            fault_ill;
  logic            fault;
  logic            st_we;
  logic [XLEN-1:0] rd_word;
  logic [7:0]      st_be;
  logic [XLEN-1:0] st_word;
  logic [XLEN-1:0] ld_data;

  // ---------------- FSM ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && init_ptr == AW'(DEPTH - 1)) state_nxt = ST_RUN;
  end

  always_comb begin
    bus.req_ready = (state == ST_RUN);
    init_we       = (state == ST_INIT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        init_ptr <= '0;
    else if (init_we) init_ptr <= init_ptr + 1'b1;
  end

  // ---------------- request decode ----------------
  always_comb begin
    accept      = bus.req_valid & bus.req_ready;
    word_idx    = bus.req_addr[AW+2:3];
    lane        = bus.req_addr[2:0];
    fault_mis   = misaligned(lane, bus.req_funct3[1:0]);
    fault_range = |bus.req_addr[ADDR_W-1:AW+3];
    fault_ill   = bus.req_write ? bus.req_funct3[F3_UNSIGNED_BIT]
                                : (bus.req_funct3 == F3_ILLEGAL_LOAD);
    fault       = fault_mis | fault_range | fault_ill;
    st_we       = accept & bus.req_write & ~fault;
    rd_word     = mem[word_idx];
  end

  dm_lane_align u_lane_align (
    .funct3  (bus.req_funct3),
    .lane    (lane),
    .st_data (bus.req_wdata),
    .rd_word (rd_word),
    .st_be   (st_be),
    .st_word (st_word),
    .ld_data (ld_data)
  );

  // ---------------- storage ----------------
  // NOTE: the array has no reset so it maps onto RAM; the INIT sweep does the zeroing.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_ptr] <= '0;
    end else if (st_we) begin
      for (int b = 0; b < DM_WORD_BYTES; b++) begin
        if (st_be[b]) mem[word_idx][8*b +: 8] <= st_word[8*b +: 8];
      end
    end
  end

  // ---------------- response ----------------
  // Data and fault hold their last value when nothing is accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_fault <= 1'b0;
    end else begin
      bus.resp_valid <= accept;
      if (accept) begin
        bus.resp_rdata <= (bus.req_write | fault) ? '0 : ld_data;
        bus.resp_fault <= fault;
      end
    end
  end

endmodule
